// File: rtl/apb_master_if.sv
// Command/response and APB signal bundle for apb_master.
// The pready signal exists only when APB_PREADY_EN is defined.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
`ifdef APB_PREADY_EN
  logic                  pready;
`endif

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pslverr,
`ifdef APB_PREADY_EN
    input  pready,
`endif
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pslverr,
`ifdef APB_PREADY_EN
    output pready,
`endif
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator: single outstanding command, SETUP/ACCESS sequencing, one-cycle response.
// Optional APB_PREADY_EN adds pready wait states with a TIMEOUT_CYCLES forced-error bound.
module apb_master #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic           clk,
  input  logic           n_rst,
  apb_master_if.master   bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_d;
  logic                  psel, psel_d, penable, penable_d, pwrite, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_d;
  logic                  rsp_valid, rsp_valid_d, rsp_err, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata, rsp_rdata_d;
  logic                  cmd_ready, done, timeout;

`ifdef APB_PREADY_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_q, wait_d;
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_PREADY_EN
      wait_q    <= '0;
`endif
    end else begin
      state     <= state_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
`ifdef APB_PREADY_EN
      wait_q    <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
`ifdef APB_PREADY_EN
    wait_d      = wait_q;
`endif
    case (state)
      IDLE:  cmd_ready = 1'b1;
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
`ifdef APB_PREADY_EN
        timeout = !bus.pready && (wait_q == CW'(TIMEOUT_CYCLES));
        done    = bus.pready || timeout;
        if (!done) wait_d = wait_q + 1'b1;
`else
        done    = 1'b1;
`endif
        cmd_ready = done;
        if (done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr || timeout;
          rsp_rdata_d = (pwrite || timeout) ? '0 : bus.prdata;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Accept overrides the IDLE return so back-to-back commands keep psel high.
    if (cmd_ready && bus.cmd_valid) begin
      pwrite_d  = bus.cmd_write;
      paddr_d   = bus.cmd_addr;
      pwdata_d  = bus.cmd_wdata;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      state_d   = SETUP;
`ifdef APB_PREADY_EN
      wait_d    = '0;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.psel      = psel;
  assign bus.penable   = penable;
  assign bus.pwrite    = pwrite;
  assign bus.paddr     = paddr;
  assign bus.pwdata    = pwdata;
endmodule

// File: tb/tb_apb_master.sv
// Directed protocol checks plus randomized traffic against a memory-level model of the slave.
module tb_apb_master;
  localparam int AW = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;
  bit rand_rdy = 1'b0;

  typedef logic [DW:0] rsp_t;  // {rdata, err}
  rsp_t exp_q[$];
  rsp_t obs_q[$];

  logic [DW-1:0] smem [8];
  logic [7:0]    serr = 8'h00;
  logic [DW-1:0] model [8];

  // Bus-functional slave: register file, per-address error mask.
  always_comb begin
    bus.prdata  = 8'hEE;
    bus.pslverr = 1'b0;
    if (bus.psel && bus.penable) begin
      bus.prdata  = smem[bus.paddr];
      bus.pslverr = serr[bus.paddr];
    end
  end

  logic slave_rdy;
`ifdef APB_PREADY_EN
  assign slave_rdy = bus.pready;
`else
  assign slave_rdy = 1'b1;
`endif

  always @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < 8; i++) smem[i] <= '0;
    end else if (bus.psel && bus.penable && bus.pwrite && slave_rdy) begin
      smem[bus.paddr] <= bus.pwdata;
    end
  end

  always @(negedge clk) if (bus.rsp_valid) obs_q.push_back({bus.rsp_rdata, bus.rsp_err});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
`ifdef APB_PREADY_EN
    if (rand_rdy) bus.pready = ($urandom_range(0, 3) != 0);
`endif
  endtask

  task automatic model_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({(w ? 8'h00 : model[a]), serr[a]});
    if (w) model[a] = d;
  endtask

  // Present a command and return at the negedge just after the accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
    bit acc = 1'b0;
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!acc && n < 64) begin
      acc = bus.cmd_ready;
      tick();
      n++;
    end
    chk("accept", 32'(acc), 32'd1);
    if (!hold) bus.cmd_valid = 1'b0;
    model_cmd(w, a, d);
  endtask

  initial begin
    int n;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit hold;

    n_rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
`ifdef APB_PREADY_EN
    bus.pready = 1'b1;
`endif
    for (int i = 0; i < 8; i++) model[i] = '0;
    tick(); tick();
    chk("rst_psel", 32'(bus.psel), 0);
    chk("rst_penable", 32'(bus.penable), 0);
    chk("rst_pwrite", 32'(bus.pwrite), 0);
    chk("rst_paddr", 32'(bus.paddr), 0);
    chk("rst_pwdata", 32'(bus.pwdata), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    n_rst = 1'b0;
    tick();

    // Single write: cycle-accurate phase checks.
    issue(1'b1, 3'h2, 8'hA5, 1'b0);
    chk("wr_setup_psel", 32'(bus.psel), 1);
    chk("wr_setup_penable", 32'(bus.penable), 0);
    chk("wr_setup_paddr", 32'(bus.paddr), 2);
    chk("wr_setup_pwdata", 32'(bus.pwdata), 32'hA5);
    chk("wr_setup_pwrite", 32'(bus.pwrite), 1);
    chk("wr_setup_ready", 32'(bus.cmd_ready), 0);
    tick();
    chk("wr_access_psel", 32'(bus.psel), 1);
    chk("wr_access_penable", 32'(bus.penable), 1);
    chk("wr_access_ready", 32'(bus.cmd_ready), 1);
    tick();
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("wr_rsp_err", 32'(bus.rsp_err), 0);
    chk("wr_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("wr_idle_psel", 32'(bus.psel), 0);
    tick();
    chk("wr_c4_psel", 32'(bus.psel), 0);
    chk("wr_c4_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("wr_idle_paddr_hold", 32'(bus.paddr), 2);

    // Read returns slave data three cycles after accept.
    issue(1'b1, 3'h6, 8'h3C, 1'b0);
    tick(); tick();
    issue(1'b0, 3'h6, 8'h00, 1'b0);
    tick(); tick();
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'(model[6]));
    chk("rd_rsp_err", 32'(bus.rsp_err), 0);

    // Slave error, then clean completion clears rsp_err.
    serr[7] = 1'b1;
    issue(1'b1, 3'h7, 8'h5A, 1'b0);
    tick(); tick();
    issue(1'b0, 3'h7, 8'h00, 1'b0);
    tick(); tick();
    chk("err_rsp_err", 32'(bus.rsp_err), 1);
    chk("err_rsp_rdata", 32'(bus.rsp_rdata), 32'h5A);
    tick();
    chk("err_hold", 32'(bus.rsp_err), 1);
    issue(1'b0, 3'h6, 8'h00, 1'b0);
    tick(); tick();
    chk("err_clear", 32'(bus.rsp_err), 0);
    chk("err_clear_rdata", 32'(bus.rsp_rdata), 32'h3C);

    // Back-to-back writes: psel stays high, responses two cycles apart.
    issue(1'b1, 3'h3, 8'h08, 1'b1);
    bus.cmd_addr  = 3'h4;
    bus.cmd_wdata = 8'h0A;
    chk("b2b_c1_paddr", 32'(bus.paddr), 3);
    tick();
    chk("b2b_c2_psel", 32'(bus.psel), 1);
    chk("b2b_c2_penable", 32'(bus.penable), 1);
    chk("b2b_c2_ready", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    model_cmd(1'b1, 3'h4, 8'h0A);
    chk("b2b_c3_psel", 32'(bus.psel), 1);
    chk("b2b_c3_penable", 32'(bus.penable), 0);
    chk("b2b_c3_paddr", 32'(bus.paddr), 4);
    chk("b2b_c3_pwdata", 32'(bus.pwdata), 32'h0A);
    chk("b2b_rsp1", 32'(bus.rsp_valid), 1);
    tick();
    chk("b2b_c4_penable", 32'(bus.penable), 1);
    chk("b2b_c4_rsp_gap", 32'(bus.rsp_valid), 0);
    tick();
    chk("b2b_rsp2", 32'(bus.rsp_valid), 1);
    chk("b2b_c5_psel", 32'(bus.psel), 0);

    // Reset during ACCESS aborts without a response.
    issue(1'b1, 3'h5, 8'h77, 1'b0);
    tick();
    chk("rst_mid_access", 32'(bus.penable), 1);
    n_rst = 1'b1;
    tick();
    chk("rst_mid_psel", 32'(bus.psel), 0);
    chk("rst_mid_penable", 32'(bus.penable), 0);
    chk("rst_mid_ready", 32'(bus.cmd_ready), 1);
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 0);
    n_rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    tick();
    chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 0);

`ifdef APB_PREADY_EN
    // Three wait states, then timeout with pready stuck low.
    issue(1'b1, 3'h1, 8'h11, 1'b0);
    bus.pready = 1'b0;
    tick();
    chk("ws_c2_penable", 32'(bus.penable), 1);
    chk("ws_c2_ready", 32'(bus.cmd_ready), 0);
    tick();
    chk("ws_c3_paddr", 32'(bus.paddr), 1);
    chk("ws_c3_rsp", 32'(bus.rsp_valid), 0);
    tick();
    chk("ws_c4_pwdata", 32'(bus.pwdata), 32'h11);
    chk("ws_c4_psel", 32'(bus.psel), 1);
    tick();
    chk("ws_c5_penable", 32'(bus.penable), 1);
    bus.pready = 1'b1;
    chk("ws_c5_ready", 32'(bus.cmd_ready), 1);
    tick();
    chk("ws_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("ws_rsp_err", 32'(bus.rsp_err), 0);
    tick();
    bus.pready = 1'b0;
    issue(1'b0, 3'h1, 8'h00, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!bus.rsp_valid && n < 40);
    chk("to_latency", 32'(n), 17);
    chk("to_rsp_err", 32'(bus.rsp_err), 1);
    chk("to_rsp_rdata", 32'(bus.rsp_rdata), 0);
    bus.pready = 1'b1;
    tick();
`endif

    // Randomized traffic; responses compared in order against the model.
    tick(); tick();
    exp_q.delete();
    obs_q.delete();
    serr = 8'($urandom);
    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      w    = 1'($urandom);
      a    = AW'($urandom);
      d    = DW'($urandom);
      hold = 1'($urandom);
      issue(w, a, d, hold);
      if (!hold) repeat ($urandom_range(0, 2)) tick();
    end
    bus.cmd_valid = 1'b0;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin tick(); n++; end
    rand_rdy = 1'b0;
    chk("rand_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      chk($sformatf("rand_rdata[%0d]", k), 32'(obs_q[k][DW:1]), 32'(exp_q[k][DW:1]));
      chk($sformatf("rand_err[%0d]", k), 32'(obs_q[k][0]), 32'(exp_q[k][0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that drives the UART peripheral's configuration/status bus from a simple command interface.
- Test-bench-side and SoC-side controllers issue single read/write commands (`cmd_*`). The block sequences the APB SETUP/ACCESS phases, captures `prdata`/`pslverr` and returns a one-cycle response.
- One transaction outstanding at a time. Back-to-back commands are supported without an idle cycle.

Parameters:
- ADDR_WIDTH, 3, width of `paddr`/`cmd_addr`.
- DATA_WIDTH, 8, width of `pwdata`/`prdata`/`cmd_wdata`/`rsp_rdata`.
- TIMEOUT_CYCLES, 15, maximum wait-state cycles in ACCESS before forced error completion. Used only with `APB_PREADY_EN`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `n_rst`  in  1  synchronous, active-high reset (1 = reset).
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  target register address.
- `cmd_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  one-cycle pulse: transaction complete.
- `rsp_rdata`  out  DATA_WIDTH  read data (0 for writes).
- `rsp_err`  out  1  `pslverr` (or timeout) for the completed transaction.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `paddr`  out  ADDR_WIDTH  APB address.
- `pwdata`  out  DATA_WIDTH  APB write data.
- `prdata`  in  DATA_WIDTH  APB read data.
- `pslverr`  in  1  APB slave error.
- `pready`  in  1  APB ready. Present only with `APB_PREADY_EN`.

Behaviour:
- **Reset:** single clock domain `clk`; reset `n_rst` is synchronous and active-high.
  - While `n_rst` = 1 at a rising edge, the next state is:
    - `state` = IDLE;
    - `psel` = `penable` = `pwrite` = 0;
    - `paddr` = 0, `pwdata` = 0;
    - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0;
    - `cmd_ready` = 1;
    - wait counter = 0.
  - Reset mid-transaction aborts it with no response pulse and returns to IDLE.
- **States:** IDLE, SETUP, ACCESS. All APB outputs are registered.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid` & `cmd_ready`: latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata`, set `psel` = 1, go to SETUP.
- **SETUP:**
  - `psel` = 1, `penable` = 0, `cmd_ready` = 0.
  - Always exactly one cycle, then ACCESS with `penable` = 1.
- **ACCESS:**
  - `psel` = 1, `penable` = 1. `paddr`/`pwrite`/`pwdata` held stable through SETUP and ACCESS.
  - Completion condition: see Optional Feature.
- **On completion (cycle C):**
  - Sample `prdata` (reads only) and `pslverr`.
  - Next cycle: `rsp_valid` = 1 for exactly one cycle, with:
    - `rsp_rdata` = sampled `prdata` for reads, 0 for writes;
    - `rsp_err` = sampled `pslverr`.
  - `rsp_rdata`/`rsp_err` hold until the next completion.
- **`cmd_ready` in ACCESS:** asserted only in the completing ACCESS cycle.
  - If `cmd_valid` is high in that cycle, the new command is latched and the FSM goes straight to SETUP (`psel` stays 1, `penable` drops to 0).
  - Otherwise it goes to IDLE (`psel` = 0, `penable` = 0).
- **Latency:** IDLE accept at cycle 0 → SETUP cycle 1 → ACCESS cycle 2 (no wait states) → `rsp_valid` cycle 3.
- **Back-to-back throughput:** one transaction per 2 cycles.
- **Ignored commands:** `cmd_valid` while `cmd_ready` = 0 is ignored; the caller must hold the command until accepted.
- **Bus outputs when idle:** `pwrite`, `paddr`, `pwdata` keep their last values in IDLE; `psel`/`penable` are both 0.

Optional Feature:
- Macro: `APB_PREADY_EN`.
- **Defined:**
  - `pready` port exists.
  - ACCESS completes in the first ACCESS cycle with `pready` = 1. While `pready` = 0, all APB outputs are held and the wait counter increments.
  - Timeout: if the counter reaches TIMEOUT_CYCLES with `pready` still 0, the transaction completes that cycle with `rsp_err` = 1 and `rsp_rdata` = 0.
  - The counter clears on entry to SETUP.
- **Undefined:**
  - No `pready` port and no counter.
  - ACCESS always lasts exactly one cycle (compatible with the UART slave, which has no wait states).

Test Plan:
1. Write: `cmd` write addr 3'h2, wdata 8'hA5 → cycle 1 `psel` = 1 `penable` = 0 `paddr` = 2 `pwdata` = A5 `pwrite` = 1; cycle 2 `penable` = 1; cycle 3 `rsp_valid` = 1, `rsp_err` = 0, `rsp_rdata` = 0; cycle 4 `psel` = 0.
2. Read: read addr 3'h6, slave drives `prdata` = 8'h3C in ACCESS → `rsp_valid` at cycle 3 with `rsp_rdata` = 3C, `rsp_err` = 0.
3. Error: read addr 3'h7 with `pslverr` = 1 in ACCESS → `rsp_err` = 1; next command's `rsp_err` returns 0 when `pslverr` = 0.
4. Back-to-back: `cmd_valid` held high with write 3'h3 = 8'h08 then write 3'h4 = 8'h0A → second SETUP immediately follows first ACCESS, `psel` never drops; two `rsp_valid` pulses 2 cycles apart.
5. Reset mid-transaction: assert `n_rst` = 1 during ACCESS → next edge `psel` = `penable` = 0, `cmd_ready` = 1, no `rsp_valid`.
6. (`APB_PREADY_EN`) `pready` low 3 cycles → ACCESS held 4 cycles, outputs stable, normal response. `pready` never high → completion after 15 wait cycles with `rsp_err` = 1.
